// File: rtl/sdram_cmd_arbiter.sv
// rtl/sdram_cmd_arbiter.sv - two-client round-robin command arbiter with refresh scheduling for an SDRAM controller
module sdram_cmd_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int BURST_LEN    = 8,
    parameter int REF_INTERVAL = 780
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ0,
    input  logic              RW0,
    input  logic [ADDR_W-1:0] ADDR0,
    output logic              GNT0,
    output logic              DONE0,
    input  logic              REQ1,
    input  logic              RW1,
    input  logic [ADDR_W-1:0] ADDR1,
    output logic              GNT1,
    output logic              DONE1,
    output logic [2:0]        CMD,
    output logic [ADDR_W-1:0] ADDR,
    input  logic              CMDACK,
    input  logic              DVALID,
    output logic              W_DATAEND,
    output logic              OWNER,
    output logic              BUSY,
    output logic              REF_MISS
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_RD     = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_REF    = 3'd4;

    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_RD   = 3'b001;
    localparam logic [2:0] CMD_WR   = 3'b010;
    localparam logic [2:0] CMD_REF  = 3'b011;

    localparam int BW = $clog2(BURST_LEN);
    localparam int TW = $clog2(REF_INTERVAL);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] BEAT_PEN  = BW'(BURST_LEN - 2);
    localparam logic [TW-1:0] REF_LAST  = TW'(REF_INTERVAL - 1);

    logic [2:0]        state_q, state_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              wde_q, wde_d;
    logic              owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              miss_q, miss_d;
    logic              rr_q, rr_d;
    logic              sel_q, sel_d;
    logic              rw_q, rw_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              pend_q, pend_d;

    logic              ref_wrap;
    logic              ref_clr;
    logic              pick;
    logic              pick_rw;
    logic [ADDR_W-1:0] pick_addr;

    assign ref_wrap  = (tmr_q == REF_LAST);
    // rr_q names the requester that wins when both are asking
    assign pick      = (REQ0 && REQ1) ? rr_q : REQ1;
    assign pick_rw   = pick ? RW1 : RW0;
    assign pick_addr = pick ? ADDR1 : ADDR0;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        wde_d   = 1'b0;
        owner_d = owner_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        rw_d    = rw_q;
        beat_d  = beat_q;
        ref_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_q || ref_wrap) begin
                    state_d = S_REF;
                    cmd_d   = CMD_REF;
                end else if (REQ0 || REQ1) begin
                    state_d = S_ISSUE;
                    sel_d   = pick;
                    rw_d    = pick_rw;
                    addr_d  = pick_addr;
                    cmd_d   = pick_rw ? CMD_WR : CMD_RD;
                end
            end
            S_ISSUE: begin
                if (CMDACK) begin
                    cmd_d   = CMD_NOP;
                    gnt_d   = sel_q ? 2'b10 : 2'b01;
                    owner_d = sel_q;
                    rr_d    = ~sel_q;
                    beat_d  = '0;
                    state_d = rw_q ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (DVALID) begin
                    if (beat_q == BEAT_LAST) begin
                        done_d  = sel_q ? 2'b10 : 2'b01;
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_WR: begin
                // beat_q is the write cycle number minus one
                if (beat_q == BEAT_LAST) begin
                    done_d  = sel_q ? 2'b10 : 2'b01;
                    beat_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                    wde_d  = (beat_q == BEAT_PEN);
                end
            end
            S_REF: begin
                if (CMDACK) begin
                    cmd_d   = CMD_NOP;
                    ref_clr = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cmd_d   = CMD_NOP;
            end
        endcase
    end

    assign tmr_d  = ref_wrap ? '0 : tmr_q + 1'b1;
    assign pend_d = ref_wrap || (pend_q && !ref_clr);
    assign miss_d = miss_q || (ref_wrap && pend_q);
    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            wde_q   <= 1'b0;
            owner_q <= 1'b0;
            busy_q  <= 1'b0;
            miss_q  <= 1'b0;
            rr_q    <= 1'b0;
            sel_q   <= 1'b0;
            rw_q    <= 1'b0;
            beat_q  <= '0;
            tmr_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            wde_q   <= wde_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            miss_q  <= miss_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            rw_q    <= rw_d;
            beat_q  <= beat_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
        end
    end

    assign CMD       = cmd_q;
    assign ADDR      = addr_q;
    assign GNT0      = gnt_q[0];
    assign GNT1      = gnt_q[1];
    assign DONE0     = done_q[0];
    assign DONE1     = done_q[1];
    assign W_DATAEND = wde_q;
    assign OWNER     = owner_q;
    assign BUSY      = busy_q;
    assign REF_MISS  = miss_q;

endmodule
